// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : keypad_scan_ctrl
//  Brief    : 4x4 keypad scan sequencer. Clears the scanner via the
//             kpdreset/resetkpd handshake, waits one column scan, samples and
//             debounces keydata, and queues each new press in a small FIFO
//             read through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES = 12,  // clocks waited after release (>=10)
    parameter int DEBOUNCE    = 3,   // equal samples for press / release
    parameter int FIFO_DEPTH  = 4,   // power of 2, >=2
    parameter int ACK_TIMEOUT = 16   // clocks allowed per resetkpd edge
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       kpdreset,
    input  logic       resetkpd,
    input  logic [7:0] keydata,
    output logic [7:0] key_out,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    output logic       ack_err,
    output logic       busy
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_DB_W   = $clog2(DEBOUNCE + 1);
    localparam int c_WAIT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int c_ACK_W  = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RELEASE = 3'd2,
        S_WAIT    = 3'd3,
        S_SAMPLE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_timeout;
    logic                w_sample;
    logic [c_ACK_W-1:0]  r_ack_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic [7:0]          r_cand;
    logic [c_DB_W-1:0]   r_cnt;
    logic [c_DB_W-1:0]   r_rel_cnt;
    logic                r_locked;
    logic [7:0]          w_cand_nxt;
    logic [c_DB_W-1:0]   w_cnt_nxt;
    logic [c_DB_W-1:0]   w_rel_nxt;
    logic                w_locked_nxt;
    logic                w_push;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs; ack wins over a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_sample    = 1'b0;
        kpdreset    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                kpdreset = 1'b1;
                if (resetkpd) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_ack_cnt == c_ACK_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!resetkpd) begin
                    w_state_nxt = S_WAIT;
                end else if (r_ack_cnt == c_ACK_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_W'(SCAN_CYCLES - 1)) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_sample    = 1'b1;
                w_state_nxt = enable ? S_CLEAR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and scan timers restart on every state entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ack_cnt  <= '0;
            r_wait_cnt <= '0;
            ack_err    <= 1'b0;
        end else begin
            if ((r_state == S_CLEAR || r_state == S_RELEASE) && w_state_nxt == r_state)
                r_ack_cnt <= r_ack_cnt + c_ACK_W'(1);
            else
                r_ack_cnt <= '0;
            if (r_state == S_WAIT && w_state_nxt == S_WAIT)
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout) ack_err <= 1'b1;
        end
    end

    // Debounce: a press fires once when the new count reaches DEBOUNCE unlocked
    always_comb begin
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_rel_nxt    = r_rel_cnt;
        w_locked_nxt = r_locked;
        w_push       = 1'b0;
        if (w_sample) begin
            if (keydata != 8'h00) begin
                w_rel_nxt = '0;
                if (keydata == r_cand) begin
                    if (r_cnt != c_DB_W'(DEBOUNCE)) w_cnt_nxt = r_cnt + c_DB_W'(1);
                end else begin
                    w_cand_nxt = keydata;
                    w_cnt_nxt  = c_DB_W'(1);
                end
                if (w_cnt_nxt == c_DB_W'(DEBOUNCE) && !r_locked) begin
                    w_push       = 1'b1;
                    w_locked_nxt = 1'b1;
                end
            end else begin
                w_cand_nxt = 8'h00;
                w_cnt_nxt  = '0;
                if (r_rel_cnt != c_DB_W'(DEBOUNCE)) w_rel_nxt = r_rel_cnt + c_DB_W'(1);
                if (w_rel_nxt == c_DB_W'(DEBOUNCE)) w_locked_nxt = 1'b0;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cand    <= 8'h00;
            r_cnt     <= '0;
            r_rel_cnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rel_cnt <= w_rel_nxt;
            r_locked  <= w_locked_nxt;
        end
    end

    // FIFO status; a full FIFO still accepts a push when the head pops together
    assign key_valid = (r_count != '0);
    assign w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop     = key_valid & key_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign key_out   = key_valid ? r_mem[r_rd_ptr] : 8'h00;

    // FIFO storage (contents are masked by key_valid, so no reset needed)
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_cand_nxt;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - c_CNT_W'(1);
            if (w_push && !w_push_ok) overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_keypad_scan_ctrl
//  Brief    : Self-checking bench for keypad_scan_ctrl. Expected key codes
//             are queued as stimulus is issued; a monitor pops them as the
//             DUT hands keys out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int c_BOUND = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       kpdreset;
    logic       resetkpd = 1'b0;
    logic [7:0] keydata = 8'h00;
    logic [7:0] key_out;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overflow;
    logic       ack_err;
    logic       busy;

    logic       scanner_ack = 1'b0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(12),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .kpdreset (kpdreset),
        .resetkpd (resetkpd),
        .keydata  (keydata),
        .key_out  (key_out),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .overflow (overflow),
        .ack_err  (ack_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Scanner model: acknowledges kpdreset half a cycle later when enabled
    always @(negedge clk) resetkpd = scanner_ack ? kpdreset : 1'b0;

    // Monitor: every accepted key must match the oldest expected code
    always @(negedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL key_pop actual=%02h required=<no key expected>", key_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (key_out !== e) begin
                    errors++;
                    $display("FAIL key_pop actual=%02h required=%02h", key_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Returns at the first negedge of a new CLEAR (kpdreset 0 -> 1)
    task automatic wait_rise();
        int n;
        n = 0;
        while (kpdreset !== 1'b0 && n < c_BOUND) begin @(negedge clk); n++; end
        while (kpdreset !== 1'b1 && n < c_BOUND) begin @(negedge clk); n++; end
        if (n >= c_BOUND) begin
            checks++;
            errors++;
            $display("FAIL wait_rise actual=timeout required=kpdreset rise");
        end
    endtask

    task automatic loops(input logic [7:0] d, input int n);
        keydata = d;
        for (int i = 0; i < n; i++) wait_rise();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < c_BOUND) begin @(negedge clk); n++; end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] codes [5];
        int         n;
        logic       saw_clear;
        codes[0] = 8'h41; codes[1] = 8'h42; codes[2] = 8'h43;
        codes[3] = 8'h44; codes[4] = 8'h45;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: reset while parked in CLEAR
        enable = 1'b1;
        wait_rise();
        chk("t1_in_clear", {31'd0, kpdreset}, 32'd1);
        pulse_reset();
        @(negedge clk);
        chk("t1_kpdreset", {31'd0, kpdreset}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_key_valid", {31'd0, key_valid}, 32'd0);
        chk("t1_key_out", {24'd0, key_out}, 32'd0);
        chk("t1_overflow", {31'd0, overflow}, 32'd0);
        chk("t1_ack_err", {31'd0, ack_err}, 32'd0);
        scanner_ack = 1'b1;

        // 2: '5' held three loops then released: exactly one key
        key_ready = 1'b1;
        wait_rise();
        exp_q.push_back(8'h35);
        loops(8'h35, 3);
        loops(8'h00, 4);
        chk("t2_drained", exp_q.size(), 32'd0);
        chk("t2_no_second", {31'd0, key_valid}, 32'd0);

        // 3: bounce 2 / gap 1 / 2 never reaches the debounce count
        loops(8'h31, 2);
        loops(8'h00, 1);
        loops(8'h31, 2);
        loops(8'h00, 3);
        chk("t3_nopush", {31'd0, key_valid}, 32'd0);

        // 4: five presses with the consumer stalled: four kept, fifth overflows
        @(posedge clk); #1 key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(codes[i]);
            loops(codes[i], 3);
            loops(8'h00, 3);
            if (i == 3) begin
                chk("t4_full_no_ovf", {31'd0, overflow}, 32'd0);
                chk("t4_full_valid", {31'd0, key_valid}, 32'd1);
            end
        end
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1 key_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_drained", exp_q.size(), 32'd0);
        chk("t4_empty", {31'd0, key_valid}, 32'd0);

        // 5: silent scanner times out, retries, then recovers
        enable = 1'b0;
        wait_idle();
        scanner_ack = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();
        enable = 1'b1;
        wait_rise();
        n = 0;
        while (kpdreset === 1'b1 && n < c_BOUND) begin n++; @(negedge clk); end
        chk("t5_clear_len", n, 32'd16);
        chk("t5_ack_err", {31'd0, ack_err}, 32'd1);
        chk("t5_kpdreset", {31'd0, kpdreset}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t5_retry", {31'd0, kpdreset}, 32'd1);
        scanner_ack = 1'b1;
        wait_rise();
        wait_rise();
        chk("t5_resumed", {31'd0, busy}, 32'd1);
        chk("t5_ack_err_sticky", {31'd0, ack_err}, 32'd1);

        // 6: enable dropped in WAIT: loop completes, then parks
        wait_rise();
        n = 0;
        while (kpdreset === 1'b1 && n < c_BOUND) begin n++; @(negedge clk); end
        repeat (4) @(negedge clk);
        chk("t6_in_wait", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        n = 0;
        saw_clear = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            if (kpdreset === 1'b1) saw_clear = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("t6_parked", {31'd0, busy}, 32'd0);
        chk("t6_no_clear", {31'd0, saw_clear}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_still_idle", {30'd0, busy, kpdreset}, 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_restart", {31'd0, kpdreset}, 32'd1);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
